// File: rtl/sfr_arb_pkg.sv
// Shared types for the SFR port arbiter.
// Port command encodings, FSM states and the latched command bundle.
package sfr_arb_pkg;

  localparam int SFR_ADDR_W = 5;
  localparam int SFR_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    SFR_WREN_IDLE  = 2'b00,
    SFR_WREN_WRITE = 2'b01,
    SFR_WREN_READ  = 2'b10
  } sfr_wren_e;

  typedef struct packed {
    logic                  we;
    logic [SFR_ADDR_W-1:0] addr;
    logic [SFR_DATA_W-1:0] wdata;
  } sfr_cmd_t;

endpackage

// File: rtl/sfr_rr_pick.sv
// Combinational round-robin picker.
// One-hot winner is the lowest index at or after ptr_i, wrapping.
module sfr_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   low;
  logic [N-1:0]   sel;
  logic [2*N-1:0] back;

  // Rotate so ptr_i lands at bit 0, isolate lowest set bit, rotate back.
  assign dbl   = {req_i, req_i} >> ptr_i;
  assign low   = dbl[N-1:0];
  assign sel   = low & (~low + N'(1));
  assign back  = {sel, sel} << ptr_i;
  assign gnt_o = back[2*N-1:N];
  assign any_o = |req_i;

endmodule

// File: rtl/sfr_port_arbiter.sv
// Arbiter for the SFR file's single port: CPU fixed priority,
// peripherals round-robin, starvation counter forces a peripheral turn.
module sfr_port_arbiter
  import sfr_arb_pkg::*;
#(
  parameter int NUM_PERIPH = 3,
  parameter int MAX_WAIT   = 4
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [SFR_ADDR_W-1:0]            cpu_addr,
  input  logic [SFR_DATA_W-1:0]            cpu_wdata,
  output logic                             cpu_gnt,
  output logic                             cpu_stall,
  output logic                             cpu_rvalid,
  input  logic [NUM_PERIPH-1:0]            p_req,
  input  logic [NUM_PERIPH-1:0]            p_we,
  input  logic [SFR_ADDR_W*NUM_PERIPH-1:0] p_addr,
  input  logic [SFR_DATA_W*NUM_PERIPH-1:0] p_wdata,
  output logic [NUM_PERIPH-1:0]            p_gnt,
  output logic [NUM_PERIPH-1:0]            p_rvalid,
  output logic [SFR_DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                       sfr_wren,
  output logic [SFR_ADDR_W-1:0]            sfr_wr_addr,
  output logic [SFR_ADDR_W-1:0]            sfr_rd_addr,
  output logic [SFR_DATA_W-1:0]            sfr_write_data,
  input  logic [SFR_DATA_W-1:0]            sfr_read_data
);

  localparam int PW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  arb_state_e            state_q;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         rr_d;
  logic [3:0]            starve_q;
  logic                  own_cpu_q;
  logic [NUM_PERIPH-1:0] own_p_q;

  logic                  cpu_gnt_q;
  logic [NUM_PERIPH-1:0] p_gnt_q;
  logic                  cpu_rvalid_q;
  logic [NUM_PERIPH-1:0] p_rvalid_q;
  logic [SFR_DATA_W-1:0] rdata_q;
  sfr_wren_e             wren_q;
  logic [SFR_ADDR_W-1:0] wr_addr_q;
  logic [SFR_ADDR_W-1:0] rd_addr_q;
  logic [SFR_DATA_W-1:0] wdata_q;

  logic [NUM_PERIPH-1:0] pick;
  logic                  p_any;
  logic                  force_p;
  logic                  cpu_win;
  logic                  p_win;
  sfr_cmd_t              cpu_cmd;
  sfr_cmd_t              p_cmd;
  sfr_cmd_t              win_cmd;

  sfr_rr_pick #(
    .N  (NUM_PERIPH),
    .PW (PW)
  ) u_pick (
    .req_i (p_req),
    .ptr_i (rr_q),
    .gnt_o (pick),
    .any_o (p_any)
  );

  assign force_p = (MW != 4'd0) && (starve_q == MW) && p_any;
  assign cpu_win = cpu_req && !force_p;
  assign p_win   = p_any && !cpu_win;
  assign cpu_cmd = {cpu_we, cpu_addr, cpu_wdata};
  assign win_cmd = cpu_win ? cpu_cmd : p_cmd;

  always_comb begin
    p_cmd = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (pick[i]) begin
        p_cmd.we    = p_we[i];
        p_cmd.addr  = p_addr[SFR_ADDR_W*i +: SFR_ADDR_W];
        p_cmd.wdata = p_wdata[SFR_DATA_W*i +: SFR_DATA_W];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (pick[i]) rr_d = PW'((i + 1) % NUM_PERIPH);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      starve_q     <= '0;
      own_cpu_q    <= 1'b0;
      own_p_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      p_gnt_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      p_rvalid_q   <= '0;
      rdata_q      <= '0;
      wren_q       <= SFR_WREN_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wdata_q      <= '0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      p_gnt_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      p_rvalid_q   <= '0;
      wren_q       <= SFR_WREN_IDLE;
      unique case (state_q)
        IDLE: begin
          if (cpu_win || p_win) begin
            state_q   <= ISSUE;
            wren_q    <= win_cmd.we ? SFR_WREN_WRITE
                                    : SFR_WREN_READ;
            wr_addr_q <= win_cmd.addr;
            rd_addr_q <= win_cmd.addr;
            if (win_cmd.we) wdata_q <= win_cmd.wdata;
            cpu_gnt_q <= cpu_win;
            p_gnt_q   <= cpu_win ? '0 : pick;
            own_cpu_q <= cpu_win;
            own_p_q   <= cpu_win ? '0 : pick;
            if (cpu_win) begin
              if (p_any && starve_q != 4'hF)
                starve_q <= starve_q + 4'd1;
            end else begin
              starve_q <= '0;
              rr_q     <= rr_d;
            end
          end
        end
        ISSUE: begin
          state_q <= (wren_q == SFR_WREN_READ) ? RD_WAIT
                                               : IDLE;
        end
        RD_WAIT: begin
          rdata_q      <= sfr_read_data;
          cpu_rvalid_q <= own_cpu_q;
          p_rvalid_q   <= own_p_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_gnt        = cpu_gnt_q;
  assign cpu_stall      = cpu_req & ~cpu_gnt_q;
  assign cpu_rvalid     = cpu_rvalid_q;
  assign p_gnt          = p_gnt_q;
  assign p_rvalid       = p_rvalid_q;
  assign rsp_rdata      = rdata_q;
  assign sfr_wren       = wren_q;
  assign sfr_wr_addr    = wr_addr_q;
  assign sfr_rd_addr    = rd_addr_q;
  assign sfr_write_data = wdata_q;

endmodule
